// File: rtl/video_timing_gen_if.sv
// ============================================================================
// Module      : video_timing_gen_if
// Description : Pixel source handshake and encoder-side video bus for
//               video_timing_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface video_timing_gen_if;
  logic [23:0] in_rgb;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_r;
  logic [7:0]  out_g;
  logic [7:0]  out_b;
  logic        out_de;
  logic        out_hsync;
  logic        out_vsync;
  logic        frame_start;
  logic        underflow;

  // Upstream pixel source and encoder-side observer
  modport master (
    output in_rgb, in_valid,
    input  in_ready, out_r, out_g, out_b, out_de, out_hsync, out_vsync,
           frame_start, underflow
  );

  // Timing generator
  modport slave (
    input  in_rgb, in_valid,
    output in_ready, out_r, out_g, out_b, out_de, out_hsync, out_vsync,
           frame_start, underflow
  );
endinterface

`default_nettype wire

// File: rtl/video_timing_gen.sv
// ============================================================================
// Module      : video_timing_gen
// Description : Raster timing generator feeding the TMDS encoders; pulls
//               pixels with valid/ready and flags underflow. Optional macro
//               VTG_TEST_PATTERN_EN replaces underflowed pixels with colour bars.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  wire logic          clk_pixel,
  input  wire logic          reset,
  input  wire logic          enable,
  video_timing_gen_if.slave  vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [31:0] C_H_LAST     = 32'(H_TOTAL - 1);
  localparam logic [31:0] C_V_LAST     = 32'(V_TOTAL - 1);
  localparam logic [31:0] C_H_ACTIVE   = 32'(H_ACTIVE);
  localparam logic [31:0] C_V_ACTIVE   = 32'(V_ACTIVE);
  localparam logic [31:0] C_HS_START   = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] C_HS_END     = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] C_VS_START   = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] C_VS_END     = 32'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;

  logic [23:0] rgb_q, rgb_d;
  logic        de_q, de_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        fs_q, fs_d;
  logic        uf_q, uf_d;

  logic [31:0] w_h;
  logic [31:0] w_v;
  logic        w_h_wrap;
  logic        w_active;
  logic        w_hs_act;
  logic        w_vs_act;
  logic        w_req;
  logic [23:0] w_fill;

  assign w_h      = 32'(h_cnt_q);
  assign w_v      = 32'(v_cnt_q);
  assign w_h_wrap = (w_h == C_H_LAST);
  assign w_active = (w_h < C_H_ACTIVE) && (w_v < C_V_ACTIVE);
  assign w_hs_act = (w_h >= C_HS_START) && (w_h < C_HS_END);
  assign w_vs_act = (w_v >= C_VS_START) && (w_v < C_VS_END);
  assign w_req    = w_active && enable;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!enable) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (w_h_wrap) begin
      h_cnt_d = '0;
      v_cnt_d = (w_v == C_V_LAST) ? '0 : v_cnt_q + VW'(1);
    end else begin
      h_cnt_d = h_cnt_q + HW'(1);
    end
  end

`ifdef VTG_TEST_PATTERN_EN
  // Bar index tracks h_cnt / (H_ACTIVE/8) without a divider.
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BCW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BCW-1:0] C_BAR_LAST = BCW'(BAR_W - 1);

  logic [BCW-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]     bar_idx_q, bar_idx_d;

  always_comb begin
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    if (!enable || w_h_wrap) begin
      bar_cnt_d = '0;
      bar_idx_d = '0;
    end else if (bar_cnt_q == C_BAR_LAST) begin
      bar_cnt_d = '0;
      bar_idx_d = bar_idx_q + 3'd1;
    end else begin
      bar_cnt_d = bar_cnt_q + BCW'(1);
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
    end else begin
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  always_comb begin
    w_fill = 24'h000000;
    case (bar_idx_q)
      3'd0:    w_fill = 24'hFFFFFF;
      3'd1:    w_fill = 24'hFFFF00;
      3'd2:    w_fill = 24'h00FFFF;
      3'd3:    w_fill = 24'h00FF00;
      3'd4:    w_fill = 24'hFF00FF;
      3'd5:    w_fill = 24'hFF0000;
      3'd6:    w_fill = 24'h0000FF;
      default: w_fill = 24'h000000;
    endcase
  end
`else
  assign w_fill = 24'h000000;
`endif

  always_comb begin
    de_d    = w_req;
    hsync_d = (enable && w_hs_act) ? HS_POL : ~HS_POL;
    vsync_d = (enable && w_vs_act) ? VS_POL : ~VS_POL;
    fs_d    = enable && (h_cnt_q == '0) && (v_cnt_q == '0);
    rgb_d   = 24'h000000;
    uf_d    = uf_q;
    if (w_req) begin
      if (vif.in_valid) begin
        rgb_d = vif.in_rgb;
      end else begin
        rgb_d = w_fill;
        uf_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      rgb_q   <= 24'h000000;
      de_q    <= 1'b0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      rgb_q   <= rgb_d;
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      fs_q    <= fs_d;
      uf_q    <= uf_d;
    end
  end

  assign vif.in_ready    = w_req;
  assign vif.out_r       = rgb_q[23:16];
  assign vif.out_g       = rgb_q[15:8];
  assign vif.out_b       = rgb_q[7:0];
  assign vif.out_de      = de_q;
  assign vif.out_hsync   = hsync_q;
  assign vif.out_vsync   = vsync_q;
  assign vif.frame_start = fs_q;
  assign vif.underflow   = uf_q;

endmodule

`default_nettype wire

// File: tb/tb_video_timing_gen.sv
// ============================================================================
// Module      : tb_video_timing_gen
// Description : Self-checking bench for video_timing_gen against a raster
//               position model (pixel index modulo frame size).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_video_timing_gen;
  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 2;
  localparam int H_BP     = 2;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 1;
  localparam int V_BP     = 1;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = H_TOTAL * V_TOTAL;

  logic clk_pixel = 1'b0;
  logic reset     = 1'b1;
  logic enable    = 1'b0;

  video_timing_gen_if vif();

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .enable    (enable),
    .vif       (vif)
  );

  always #5 clk_pixel = ~clk_pixel;

  int          checks   = 0;
  int          failures = 0;
  int          pos      = 0;
  bit          known    = 1'b0;
  bit          exp_uf   = 1'b0;
  logic [23:0] pix      = 24'h000001;
  int          n_beat, n_de, n_fs, n_hs, n_vs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] bar_colour(input int h);
`ifdef VTG_TEST_PATTERN_EN
    logic [23:0] tbl [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    return tbl[h / (H_ACTIVE / 8)];
`else
    return (h < 0) ? 24'hFFFFFF : 24'h000000;
`endif
  endfunction

  task automatic clear_counts();
    n_beat = 0; n_de = 0; n_fs = 0; n_hs = 0; n_vs = 0;
  endtask

  // One pixel clock: drive inputs, check in_ready, predict, then check outputs.
  task automatic cycle(input bit r, input bit e, input bit v, input logic [23:0] d);
    int h, ln;
    bit act, e_de, e_hs, e_vs, e_fs;
    logic [23:0] e_rgb;
    reset = r; enable = e; vif.in_valid = v; vif.in_rgb = d;
    h   = pos % H_TOTAL;
    ln  = pos / H_TOTAL;
    act = (h < H_ACTIVE) && (ln < V_ACTIVE);
    #1;
    if (known) begin
      check("in_ready", 32'(vif.in_ready), 32'(e && act));
      if (e && act && v) n_beat++;
    end
    e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_rgb = 24'h0;
    if (r) begin
      exp_uf = 1'b0; pos = 0; known = 1'b1;
    end else if (!e) begin
      pos = 0;
    end else begin
      e_de = act;
      e_hs = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
      e_vs = !((ln >= V_ACTIVE + V_FP) && (ln < V_ACTIVE + V_FP + V_SYNC));
      e_fs = (pos == 0);
      if (act) begin
        if (v) e_rgb = d;
        else begin
          e_rgb  = bar_colour(h);
          exp_uf = 1'b1;
        end
      end
      pos = (pos + 1) % FRAME;
    end
    @(posedge clk_pixel);
    #1;
    if (known) begin
      check("out_de", 32'(vif.out_de), 32'(e_de));
      check("out_hsync", 32'(vif.out_hsync), 32'(e_hs));
      check("out_vsync", 32'(vif.out_vsync), 32'(e_vs));
      check("frame_start", 32'(vif.frame_start), 32'(e_fs));
      check("out_rgb", 32'({vif.out_r, vif.out_g, vif.out_b}), 32'(e_rgb));
      check("underflow", 32'(vif.underflow), 32'(exp_uf));
      n_de += int'(vif.out_de);
      n_fs += int'(vif.frame_start);
      n_hs += int'(!vif.out_hsync);
      n_vs += int'(!vif.out_vsync);
    end
  endtask

  task automatic run_until(input int target);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (pos == target) return;
      cycle(1'b0, 1'b1, 1'b1, pix);
      pix = pix + 24'd1;
    end
    check("run_until_bound", 32'(pos), 32'(target));
  endtask

  initial begin
    vif.in_valid = 1'b0;
    vif.in_rgb   = 24'h0;
    clear_counts();

    cycle(1'b1, 1'b0, 1'b0, 24'h0);
    cycle(1'b1, 1'b1, 1'b1, 24'h0);
    check("reset_de", 32'(vif.out_de), 32'd0);
    check("reset_hsync", 32'(vif.out_hsync), 32'd1);

    // One clean frame with incrementing pixel data.
    clear_counts();
    for (int i = 0; i < FRAME; i++) begin
      cycle(1'b0, 1'b1, 1'b1, pix);
      pix = pix + 24'd1;
      if (i == 0) begin
        check("first_de", 32'(vif.out_de), 32'd1);
        check("first_fs", 32'(vif.frame_start), 32'd1);
      end
    end
    check("frame_beats", 32'(n_beat), 32'd32);
    check("frame_de", 32'(n_de), 32'd32);
    check("frame_fs", 32'(n_fs), 32'd1);
    check("frame_hs_low", 32'(n_hs), 32'(2 * V_TOTAL));
    check("frame_vs_low", 32'(n_vs), 32'(H_TOTAL));

    // Single underflowed pixel at (3,1).
    clear_counts();
    for (int i = 0; i < FRAME; i++) begin
      cycle(1'b0, 1'b1, pos != (1 * H_TOTAL + 3), pix);
      pix = pix + 24'd1;
    end
    check("uf_sticky", 32'(vif.underflow), 32'd1);
    check("uf_frame_beats", 32'(n_beat), 32'd31);
    check("uf_frame_fs", 32'(n_fs), 32'd1);

    // Enable dropped at (5,2) for three cycles.
    run_until(2 * H_TOTAL + 5);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1, pix);
      check("idle_de", 32'(vif.out_de), 32'd0);
    end
    cycle(1'b0, 1'b1, 1'b1, pix);
    check("restart_fs", 32'(vif.frame_start), 32'd1);
    check("restart_uf_kept", 32'(vif.underflow), 32'd1);

    // Reset pulsed in the front porch (h=9).
    run_until(9);
    cycle(1'b1, 1'b1, 1'b1, pix);
    check("midreset_uf", 32'(vif.underflow), 32'd0);
    cycle(1'b0, 1'b1, 1'b1, pix);
    check("midreset_fs", 32'(vif.frame_start), 32'd1);

    // Randomised traffic with occasional enable drops and resets.
    for (int i = 0; i < 8 * FRAME; i++) begin
      cycle(($urandom % 300) == 0, ($urandom % 16) != 0, ($urandom % 4) != 0,
            24'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
